// File: rtl/mem_bus_if.sv
// Wishbone master bridge between the CPU memory stage and the bus.
// Holds one access at a time and stalls the pipeline until its ack.
//
// state          | meaning
// IDLE           | no access outstanding; a request launches a bus cycle
// BUSY           | bus cycle in flight, waiting for wb_ack_i
// WAIT_FOR_STALL | access done but pipeline frozen; present buffered read data
module mem_bus_if (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o
);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] rd_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      rd_buf    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_ce_i && !flush) begin
            wb_addr_o <= cpu_addr_i;
            wb_data_o <= cpu_data_i;
            wb_sel_o  <= cpu_sel_i;
            wb_we_o   <= cpu_we_i;
            wb_stb_o  <= 1'b1;
            wb_cyc_o  <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Flush wins over a coincident ack: the access is abandoned.
          if (flush) begin
            wb_addr_o <= '0;
            wb_data_o <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            rd_buf    <= '0;
            state     <= IDLE;
          end else if (wb_ack_i) begin
            wb_addr_o <= '0;
            wb_data_o <= '0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            rd_buf    <= wb_data_i;
            state     <= (stall != 6'd0) ? WAIT_FOR_STALL : IDLE;
          end
        end
        WAIT_FOR_STALL: begin
          if (stall == 6'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      case (state)
        IDLE: stallreq = cpu_ce_i && !flush;
        BUSY: begin
          stallreq = !wb_ack_i;
          if (wb_ack_i) cpu_data_o = wb_data_i;
        end
        WAIT_FOR_STALL: cpu_data_o = rd_buf;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: directed vector table, corner-case sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;

  int n_chk = 0;
  int n_fail = 0;

  mem_bus_if dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ce, flush, ack;
    logic [5:0]  stall;
    logic [31:0] addr, data;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wbd;
    logic        e_sr;
    logic [31:0] e_cpu;
    logic        e_stb;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic ce, logic fl, logic ack, logic [5:0] st,
                              logic [31:0] a, logic [31:0] d, logic we, logic [3:0] sel,
                              logic [31:0] wbd, logic e_sr, logic [31:0] e_cpu,
                              logic e_stb, logic [31:0] e_addr, logic e_we,
                              logic [3:0] e_sel, logic [31:0] e_wd);
    vec_t v;
    v.rst = r; v.ce = ce; v.flush = fl; v.ack = ack; v.stall = st;
    v.addr = a; v.data = d; v.we = we; v.sel = sel; v.wbd = wbd;
    v.e_sr = e_sr; v.e_cpu = e_cpu; v.e_stb = e_stb; v.e_addr = e_addr;
    v.e_we = e_we; v.e_sel = e_sel; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic ce, logic fl, logic ack, logic [5:0] st,
                       logic [31:0] a, logic [31:0] d, logic we, logic [3:0] sel,
                       logic [31:0] wbd);
    rst = r; cpu_ce_i = ce; flush = fl; wb_ack_i = ack; stall = st;
    cpu_addr_i = a; cpu_data_i = d; cpu_we_i = we; cpu_sel_i = sel; wb_data_i = wbd;
  endtask

  task automatic apply(logic r, logic ce, logic fl, logic ack, logic [5:0] st,
                       logic [31:0] a, logic [31:0] d, logic we, logic [3:0] sel,
                       logic [31:0] wbd);
    @(negedge clk);
    drive(r, ce, fl, ack, st, a, d, we, sel, wbd);
    #1;
  endtask

  function automatic logic [71:0] bus_now();
    return {wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o[31:0]};
  endfunction

  // Reference model: one outstanding request plus optional held read data.
  logic        m_pending, m_holding;
  logic [31:0] m_buf, m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_sel;

  task automatic model_edge();
    if (rst) begin
      m_pending = 0; m_holding = 0; m_buf = 0;
    end else if (m_pending) begin
      m_pending = 0;
      if (flush) m_buf = 0;
      else if (wb_ack_i) begin
        m_buf = wb_data_i;
        m_holding = (stall != 0);
      end else m_pending = 1;
    end else if (m_holding) begin
      if (stall == 0) m_holding = 0;
    end else if (cpu_ce_i && !flush) begin
      m_pending = 1;
      m_addr = cpu_addr_i; m_wdata = cpu_data_i; m_we = cpu_we_i; m_sel = cpu_sel_i;
    end
  endtask

  initial begin
    logic        e_sr;
    logic [31:0] e_cpu;
    logic [71:0] e_bus;
    vec_t v;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // idx 0: reset, 1-5: read with two wait states, 6-9: write, 10-14: ack under stall
    vecs.push_back(mk(1,1,0,0,6'h00,32'h0,32'h0,0,4'h0,32'h0,          0,32'h0,0,32'h0,0,4'h0,32'h0));
    vecs.push_back(mk(0,1,0,0,6'h00,32'h10,32'h0,0,4'hF,32'h0,         1,32'h0,0,32'h0,0,4'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,6'h00,32'h0,32'h0,0,4'h0,32'h0,          1,32'h0,1,32'h10,0,4'hF,32'h0));
    vecs.push_back(mk(0,0,0,0,6'h00,32'h0,32'h0,0,4'h0,32'h0,          1,32'h0,1,32'h10,0,4'hF,32'h0));
    vecs.push_back(mk(0,0,0,1,6'h00,32'h0,32'h0,0,4'h0,32'hDEADBEEF,   0,32'hDEADBEEF,1,32'h10,0,4'hF,32'h0));
    vecs.push_back(mk(0,0,0,0,6'h00,32'h0,32'h0,0,4'h0,32'h0,          0,32'h0,0,32'h0,0,4'h0,32'h0));
    vecs.push_back(mk(0,1,0,0,6'h00,32'h20,32'h1234,1,4'h3,32'h0,      1,32'h0,0,32'h0,0,4'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,6'h00,32'h0,32'hFFFF,0,4'h0,32'h0,       1,32'h0,1,32'h20,1,4'h3,32'h1234));
    vecs.push_back(mk(0,0,0,1,6'h00,32'h0,32'h0,0,4'h0,32'h55AA,       0,32'h55AA,1,32'h20,1,4'h3,32'h1234));
    vecs.push_back(mk(0,0,0,0,6'h00,32'h0,32'h0,0,4'h0,32'h0,          0,32'h0,0,32'h0,0,4'h0,32'h0));
    vecs.push_back(mk(0,1,0,0,6'h00,32'h40,32'h0,0,4'hF,32'h0,         1,32'h0,0,32'h0,0,4'h0,32'h0));
    vecs.push_back(mk(0,0,0,1,6'h0F,32'h0,32'h0,0,4'h0,32'hCAFEF00D,   0,32'hCAFEF00D,1,32'h40,0,4'hF,32'h0));
    vecs.push_back(mk(0,1,0,0,6'h0F,32'h44,32'h0,0,4'hF,32'h0,         0,32'hCAFEF00D,0,32'h0,0,4'h0,32'h0));
    vecs.push_back(mk(0,1,0,0,6'h00,32'h44,32'h0,0,4'hF,32'h0,         0,32'hCAFEF00D,0,32'h0,0,4'h0,32'h0));
    vecs.push_back(mk(0,0,0,0,6'h00,32'h0,32'h0,0,4'h0,32'h0,          0,32'h0,0,32'h0,0,4'h0,32'h0));

    foreach (vecs[i]) begin
      v = vecs[i];
      apply(v.rst, v.ce, v.flush, v.ack, v.stall, v.addr, v.data, v.we, v.sel, v.wbd);
      chk($sformatf("vec%0d_stallreq", i), stallreq, v.e_sr);
      chk($sformatf("vec%0d_cpu_data", i), cpu_data_o, v.e_cpu);
      chk($sformatf("vec%0d_bus", i), bus_now(),
          {v.e_stb, v.e_stb, v.e_we, v.e_sel, v.e_addr, v.e_wd});
    end

    // flush in IDLE blocks the request; flush+ack in BUSY abandons it
    apply(0,1,1,0,6'h00,32'h80,0,0,4'hF,0);  chk("flush_idle_sr", stallreq, 1'b0);
    apply(0,0,0,0,6'h00,0,0,0,0,0);          chk("flush_idle_nostart", wb_stb_o, 1'b0);
    apply(0,1,0,0,6'h00,32'h84,0,0,4'hF,0);  chk("flush_req_sr", stallreq, 1'b1);
    apply(0,0,1,1,6'h3F,0,0,0,0,32'h11112222);
    chk("flush_ack_stb", wb_stb_o, 1'b1);
    chk("flush_ack_cpu", cpu_data_o, 32'h11112222);
    apply(0,1,0,0,6'h3F,32'h88,0,0,4'hF,0);
    chk("flush_after_bus", bus_now(), 72'h0);
    chk("flush_after_cpu", cpu_data_o, 32'h0);
    chk("flush_after_idle", stallreq, 1'b1);
    apply(0,0,0,1,6'h00,0,0,0,0,32'hAAAA);
    chk("flush_next_addr", wb_addr_o, 32'h88);
    chk("flush_next_cpu", cpu_data_o, 32'hAAAA);

    // reset in the middle of a bus cycle, then a stale ack
    apply(0,1,0,0,6'h00,32'h100,0,0,4'hF,0); chk("rst_req_sr", stallreq, 1'b1);
    apply(0,0,0,0,6'h00,0,0,0,0,0);          chk("rst_busy_stb", wb_stb_o, 1'b1);
    apply(1,0,0,1,6'h00,0,0,0,0,32'h77);
    chk("rst_active_sr", stallreq, 1'b0);
    chk("rst_active_cpu", cpu_data_o, 32'h0);
    apply(0,0,0,1,6'h01,0,0,0,0,32'h99);
    chk("rst_after_bus", bus_now(), 72'h0);
    chk("rst_stale_sr", stallreq, 1'b0);
    chk("rst_stale_cpu", cpu_data_o, 32'h0);
    apply(0,0,0,0,6'h01,0,0,0,0,0);          chk("rst_no_wait", cpu_data_o, 32'h0);

    // back-to-back reads: second cycle launches one edge after the first ack
    apply(0,1,0,0,6'h00,32'h200,0,0,4'hF,0);  chk("b2b_req_sr", stallreq, 1'b1);
    apply(0,1,0,1,6'h00,32'h204,0,0,4'hF,32'hB1);
    chk("b2b_ack1_addr", wb_addr_o, 32'h200);
    chk("b2b_ack1_cpu", cpu_data_o, 32'hB1);
    apply(0,1,0,0,6'h00,32'h204,0,0,4'hF,0);
    chk("b2b_gap_stb", wb_stb_o, 1'b0);
    chk("b2b_gap_sr", stallreq, 1'b1);
    apply(0,0,0,1,6'h00,0,0,0,0,32'hB2);
    chk("b2b_ack2_bus", {wb_stb_o, wb_addr_o}, {1'b1, 32'h204});
    chk("b2b_ack2_cpu", cpu_data_o, 32'hB2);
    apply(0,0,0,0,6'h00,0,0,0,0,0);           chk("b2b_end_stb", wb_stb_o, 1'b0);

    // random traffic against the model
    apply(1,0,0,0,0,0,0,0,0,0);
    @(posedge clk);
    model_edge();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 49) == 0, 1'($urandom()), $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0,
            ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'h00,
            $urandom(), $urandom(), 1'($urandom()), 4'($urandom()), $urandom());
      #1;
      e_sr  = !rst && ((!m_pending && !m_holding && cpu_ce_i && !flush) ||
                       (m_pending && !wb_ack_i));
      e_cpu = rst ? 32'h0 : (m_pending && wb_ack_i) ? wb_data_i :
              m_holding ? m_buf : 32'h0;
      e_bus = m_pending ? {1'b1, 1'b1, m_we, m_sel, m_addr, m_wdata} : 72'h0;
      chk($sformatf("rnd%0d_stallreq", i), stallreq, e_sr);
      chk($sformatf("rnd%0d_cpu_data", i), cpu_data_o, e_cpu);
      chk($sformatf("rnd%0d_bus", i), bus_now(), e_bus);
      @(posedge clk);
      model_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_if.md
MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 SHALL have port clk  in  1  pipeline clock; all state changes on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port stall  in  6  pipeline stall vector from ctrl; bit i=1 freezes stage i.
REQ-004 SHALL have port flush  in  1  pipeline flush (exception); abandons the outstanding access.
REQ-005 SHALL have port cpu_ce_i  in  1  CPU-side access request.
REQ-006 SHALL have port cpu_addr_i  in  32  CPU byte address.
REQ-007 SHALL have port cpu_data_i  in  32  CPU write data.
REQ-008 SHALL have port cpu_we_i  in  1  1 = write, 0 = read.
REQ-009 SHALL have port cpu_sel_i  in  4  byte lane enables.
REQ-010 SHALL have port cpu_data_o  out  32  read data returned to the pipeline.
REQ-011 SHALL have port stallreq  out  1  stall request to ctrl while the access is pending.
REQ-012 SHALL have port wb_data_i  in  32  bus read data.
REQ-013 SHALL have port wb_ack_i  in  1  bus cycle acknowledge.
REQ-014 SHALL have ports wb_addr_o (32), wb_data_o (32), wb_sel_o (4), wb_we_o (1), wb_stb_o (1), wb_cyc_o (1), all out and registered: Wishbone master signals.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, BUSY, WAIT_FOR_STALL.
REQ-016 IDLE, cpu_ce_i=1, flush=0: next edge SHALL load wb_addr_o/wb_data_o/wb_we_o/wb_sel_o from the cpu_* inputs, set wb_stb_o=wb_cyc_o=1, and go to BUSY.
REQ-017 IDLE, cpu_ce_i=0 or flush=1: SHALL stay IDLE with bus outputs unchanged (idle values).
REQ-018 BUSY, wb_ack_i=1: next edge SHALL drive all wb_* outputs to 0, latch wb_data_i into an internal read buffer, and go to WAIT_FOR_STALL if stall!=0, otherwise to IDLE.
REQ-019 BUSY, wb_ack_i=0: SHALL hold all wb_* outputs stable.
REQ-020 BUSY, flush=1: SHALL take priority over wb_ack_i; next edge SHALL drive all wb_* outputs to 0, clear the read buffer, and go to IDLE.
REQ-021 WAIT_FOR_STALL: SHALL go to IDLE on the first edge with stall==0; bus outputs SHALL stay idle.
REQ-022 stallreq SHALL be combinational: 1 in IDLE when cpu_ce_i=1 and flush=0; 1 in BUSY when wb_ack_i=0; 0 otherwise.
REQ-023 cpu_data_o SHALL be combinational: wb_data_i in BUSY with wb_ack_i=1; the read buffer in WAIT_FOR_STALL; 0 otherwise.
REQ-024 Access latency: stallreq SHALL be asserted from the request cycle through the ack cycle, and deasserted combinationally in the ack cycle.
REQ-025 Write accesses SHALL follow the same FSM; cpu_data_o is don't-care for writes but SHALL obey REQ-023.
REQ-026 A new request arriving in WAIT_FOR_STALL SHALL NOT start a bus cycle until the FSM returns to IDLE.

Reset
REQ-027 rst=1 SHALL force state IDLE, all wb_* outputs to 0, and the read buffer to 0 on the next edge, overriding any in-flight cycle; a later ack SHALL be ignored.
REQ-028 While rst=1, stallreq SHALL be 0 and cpu_data_o SHALL be 0.

Verification
REQ-029 Read, ack after 2 wait cycles: addr 0x00000010, wb_data_i 0xDEADBEEF -> stb/cyc high for 3 cycles, stallreq high for 3 cycles then low, cpu_data_o=0xDEADBEEF in the ack cycle.
REQ-030 Write with sel 4'b0011 at 0x20, data 0x1234: wb_we_o=1, wb_sel_o=0011, wb_data_o=0x1234 held until ack, then all 0.
REQ-031 Ack while stall=6'b001111 for 2 cycles: FSM in WAIT_FOR_STALL, cpu_data_o holds the latched data for 2 cycles, then IDLE.
REQ-032 Flush and ack in the same BUSY cycle -> bus outputs 0, read buffer 0, IDLE; no WAIT_FOR_STALL entry.
REQ-033 rst asserted mid-BUSY -> all outputs 0 next edge; a subsequent ack produces no stallreq or data change.
REQ-034 Back-to-back reads with stall=0 -> second cycle starts one edge after the first ack; no overlap of stb.
